// File: rtl/dmem_arbiter_if.sv
// CPU, DMA and data-memory signals shared by the data-memory arbiter.
// slave is the arbiter's view; master is the surrounding pipeline/DMA/memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wd;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wd,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wd,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_we, mem_addr, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority with same-cycle read, DMA starvation guard and locked bursts.
// Grant is combinational; DMA read data is one cycle later; losers are held off via cpu_stall / ~dma_gnt.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int MAX_BURST  = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [0:0] ARB_CPU = 1'b0;
  localparam logic [0:0] ARB_DMA = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] BURST_LIM  = 4'(MAX_BURST);
  localparam logic       LOCK_EN    = (MAX_BURST > 1);

  logic [0:0]        state;
  logic [3:0]        starve_cnt;
  logic [3:0]        beat_cnt;
  logic              dma_win;
  logic              cpu_win;
  logic              beat_last;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wd_mux;

  // Grants are gated by reset so nothing reaches the memory while rst is low.
  always_comb begin
    dma_win = 1'b0;
    cpu_win = 1'b0;
    if (rst) begin
      if (state == ARB_DMA) begin
        dma_win = bus.dma_req;
      end else begin
        dma_win = bus.dma_req & (~bus.cpu_req | (starve_cnt == STARVE_LIM));
        cpu_win = bus.cpu_req & ~dma_win;
      end
    end
  end

  assign addr_mux  = dma_win ? bus.dma_addr : bus.cpu_addr;
  assign wd_mux    = dma_win ? bus.dma_wd   : bus.cpu_wd;
  assign beat_last = ((beat_cnt + 4'd1) == BURST_LIM);

  assign bus.mem_we     = dma_win ? bus.dma_we : (cpu_win & bus.cpu_we);
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wd     = wd_mux;
  assign bus.cpu_rdata  = bus.mem_rd;
  assign bus.cpu_stall  = rst & bus.cpu_req & ~cpu_win;
  assign bus.dma_gnt    = dma_win;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_CPU;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= dma_win & ~bus.dma_we;
      if (dma_win & ~bus.dma_we) rdata_q <= bus.mem_rd;

      if (dma_win | ~bus.dma_req) starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;

      case (state)
        ARB_CPU: begin
          if (dma_win & bus.dma_lock & LOCK_EN) begin
            state    <= ARB_DMA;
            beat_cnt <= 4'd1;
          end
        end
        default: begin
          // In ARB_DMA a request is always granted, so dma_req=1 here means a beat was taken.
          if (~bus.dma_req | ~bus.dma_lock | beat_last) begin
            state      <= ARB_CPU;
            beat_cnt   <= '0;
            starve_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
      endcase
    end
  end
endmodule
